// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: instruction formats, opcodes,
// FSM states and a range-check helper used by the packer.
package imm_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // True when every bit selected by mask carries the same value, i.e. the
    // immediate is a proper sign extension above the field's top bit.
    function automatic logic sign_run_ok(input logic [31:0] imm, input logic [31:0] mask);
        return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational packer: places register fields and an immediate into an RV32I
// word, substituting a NOP and flagging an error for unencodable requests.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    always_comb begin
        instr = NOP_INSTR;
        err   = 1'b0;
        case (fmt)
            FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                err   = !sign_run_ok(imm, 32'hFFFF_F800);
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err   = !sign_run_ok(imm, 32'hFFFF_F800);
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err   = !sign_run_ok(imm, 32'hFFFF_F000) || imm[0];
            end
            FMT_U: begin
                instr = {imm[31:12], rd, opcode};
                err   = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err   = !sign_run_ok(imm, 32'hFFF0_0000) || imm[0];
            end
            default: err = 1'b1;
        endcase
        // A rejected request must never leak a partially built word.
        if (err) begin
            instr = NOP_INSTR;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Streams encoded instruction words with sequential addresses to the
// instruction-memory loader, one run at a time, counting encode errors.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  run_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              done,
    output logic [CNT_W-1:0]  err_cnt
);

    state_e             state;
    state_e             state_next;
    logic [ADDR_W-1:0]  ptr;
    logic [CNT_W-1:0]   remaining;
    logic [31:0]        pack_instr;
    logic               pack_err;
    logic               accept;

    imm_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    // The single output register may be refilled in the cycle it is drained.
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign done     = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (run_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && remaining == CNT_W'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                ptr       <= base_addr;
                remaining <= run_len;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= pack_instr;
                out_addr  <= ptr;
                out_err   <= pack_err;
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
                if (pack_err && err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
